// File: rtl/branch_pkg.sv
// Shared definitions for the decode-stage branch resolver.
// Contents: opcode constants, condition-code enum, resolver FSM states,
// and bit positions of Z/V/N within the {Z,V,N} flag vector.
package branch_pkg;

    localparam logic [3:0] OP_B  = 4'b1100;
    localparam logic [3:0] OP_BR = 4'b1101;

    typedef enum logic [2:0] {
        CC_NE  = 3'b000,
        CC_EQ  = 3'b001,
        CC_GT  = 3'b010,
        CC_LT  = 3'b011,
        CC_GTE = 3'b100,
        CC_LTE = 3'b101,
        CC_OV  = 3'b110,
        CC_AL  = 3'b111
    } cond_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HAZ  = 1'b1
    } state_t;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition evaluator.
// Ports:
//   i_ccc    in  3  condition code (inst[11:9])
//   i_flags  in  3  flag vector {Z,V,N}
//   o_taken  out 1  condition satisfied
module branch_cond_eval (
    input  logic [2:0] i_ccc,
    input  logic [2:0] i_flags,
    output logic       o_taken
);
    import branch_pkg::*;

    logic w_z, w_v, w_n;

    assign w_z = i_flags[FLAG_Z];
    assign w_v = i_flags[FLAG_V];
    assign w_n = i_flags[FLAG_N];

    always_comb begin
        o_taken = 1'b0;
        unique case (cond_t'(i_ccc))
            CC_NE:  o_taken = ~w_z;
            CC_EQ:  o_taken = w_z;
            CC_GT:  o_taken = ~w_z & ~w_n;
            CC_LT:  o_taken = w_n;
            CC_GTE: o_taken = ~w_n;
            CC_LTE: o_taken = w_n | w_z;
            CC_OV:  o_taken = w_v;
            CC_AL:  o_taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolver. Owns the {Z,V,N} flag register, resolves
// B (PC-relative) and BR (register) branches, and produces predictor update
// strobes and a Fetch redirect. A conditional branch that meets an EX-stage
// flag write is held for one cycle (stall_req) and then resolved from the
// freshly registered flags; there is no flag bypass.
// Optional feature: define BRANCH_STATS_EN to build saturating statistics
// counters; otherwise stat_* are tied to zero.
// Ports:
//   clk, rst                       clock, async active-high reset
//   id_valid/id_inst/id_pc_curr    IF/ID instruction and PC
//   id_prediction/_predicted_target  fetch-time prediction
//   id_rs_data                     BR target operand
//   id_stall_ext                   external hold of IF/ID
//   ex_flag_wen/ex_flags           EX flag writes {Z,V,N}
//   flags                          flag register
//   stall_req                      flag hazard stall request
//   is_branch/actual_taken         resolve pulse and outcome
//   branch_target/redirect_PC      computed target / Fetch redirect address
//   wen_BTB/wen_BHT/update_PC/flush_IF_ID  update strobes
//   stat_*                         statistics counters
module branch_resolve_unit #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [15:0]       id_inst,
    input  logic [ADDR_W-1:0] id_pc_curr,
    input  logic [1:0]        id_prediction,
    input  logic [ADDR_W-1:0] id_predicted_target,
    input  logic [15:0]       id_rs_data,
    input  logic              id_stall_ext,
    input  logic [2:0]        ex_flag_wen,
    input  logic [2:0]        ex_flags,
    output logic [2:0]        flags,
    output logic              stall_req,
    output logic              is_branch,
    output logic              actual_taken,
    output logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] redirect_PC,
    output logic              wen_BTB,
    output logic              wen_BHT,
    output logic              update_PC,
    output logic              flush_IF_ID,
    output logic [CNT_W-1:0]  stat_branches,
    output logic [CNT_W-1:0]  stat_mispredicts,
    output logic [CNT_W-1:0]  stat_haz_stalls
);
    import branch_pkg::*;

    logic [2:0]        r_flags;
    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_is_br;
    logic              w_is_reg;
    logic              w_haz;
    logic              w_taken;
    logic              w_stall;
    logic              w_resolve;
    logic              w_res;
    logic              w_mispred;
    logic              w_miscomp;
    logic [ADDR_W-1:0] w_pc_plus2;
    logic [ADDR_W-1:0] w_offset;
    logic [ADDR_W-1:0] w_target;

    assign w_is_reg = (id_inst[15:12] == OP_BR);
    assign w_is_br  = id_valid & ((id_inst[15:12] == OP_B) | w_is_reg);
    // Unconditional branches never read flags, so EX writes cannot hazard them.
    assign w_haz    = (|ex_flag_wen) & (cond_t'(id_inst[11:9]) != CC_AL);

    // Sign-extended 9-bit word offset, scaled to bytes.
    assign w_offset   = {{(ADDR_W-10){id_inst[8]}}, id_inst[8:0], 1'b0};
    assign w_pc_plus2 = id_pc_curr + ADDR_W'(2);
    assign w_target   = w_is_reg ? ADDR_W'(id_rs_data) : (w_pc_plus2 + w_offset);

    branch_cond_eval u_cond (
        .i_ccc   (id_inst[11:9]),
        .i_flags (r_flags),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ex_flag_wen[i]) r_flags[i] <= ex_flags[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_resolve   = 1'b0;
        if (!w_is_br) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_haz) begin
                        w_stall     = 1'b1;
                        w_state_nxt = S_HAZ;
                    end else if (!id_stall_ext) begin
                        w_resolve = 1'b1;
                    end
                end
                S_HAZ: begin
                    if (!id_stall_ext) begin
                        w_resolve   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Gating with rst makes stall_req and strobes drop the moment reset rises.
    assign w_res     = w_resolve & ~rst;
    assign w_mispred = (id_prediction[1] != w_taken);
    assign w_miscomp = (id_predicted_target != w_target);

    assign flags         = r_flags;
    assign stall_req     = w_stall & ~rst;
    assign is_branch     = w_res;
    assign actual_taken  = w_res & w_taken;
    assign branch_target = w_target;
    assign redirect_PC   = w_taken ? w_target : w_pc_plus2;
    assign wen_BTB       = w_res & (w_taken | w_miscomp);
    assign wen_BHT       = w_res & w_mispred;
    assign update_PC     = w_res & (w_mispred | (w_taken & w_miscomp));
    assign flush_IF_ID   = update_PC;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] r_stat_br;
    logic [CNT_W-1:0] r_stat_mis;
    logic [CNT_W-1:0] r_stat_stl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
            r_stat_stl <= '0;
        end else begin
            if (is_branch && (r_stat_br != '1))  r_stat_br  <= r_stat_br + CNT_W'(1);
            if (update_PC && (r_stat_mis != '1)) r_stat_mis <= r_stat_mis + CNT_W'(1);
            if (stall_req && (r_stat_stl != '1)) r_stat_stl <= r_stat_stl + CNT_W'(1);
        end
    end

    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mis;
    assign stat_haz_stalls  = r_stat_stl;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
    assign stat_haz_stalls  = '0;
`endif

endmodule
